// File: rtl/regfile_uart_dump.sv
// Serial dump engine: walks register-file addresses 0..NREGS-1, turns each value
// into two uppercase ASCII hex characters and sends the line over 8N1 UART.
module regfile_uart_dump #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NREGS        = 8,
  parameter int AW           = 3,
  parameter int DW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic          uart_txd,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  state_t        state, state_next;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [1:0]    char_idx;  // 0 = high nibble, 1 = low nibble, 2..3 = separator
  logic [AW-1:0] idx;
  logic [7:0]    val;
  logic [7:0]    shift;
  logic          txd;
  logic          bit_end;
  logic          frame_end;
  logic          last_char;
  logic [7:0]    next_char;

  assign ra       = idx;
  assign uart_txd = txd;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case statement can leave it unassigned (no latch).
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    bit_end    = (state == SEND) && (clk_cnt == CW'(CLKS_PER_BIT - 1));
    frame_end  = bit_end && (bit_idx == 4'd9);
    last_char  = (char_idx == 2'd3) || ((char_idx == 2'd2) && (idx != LAST));
    next_char  = 8'h0A;
    case (char_idx)
      2'd0:    next_char = hex_char(val[3:0]);
      2'd1:    next_char = (idx == LAST) ? 8'h0D : 8'h20;
      default: next_char = 8'h0A;
    endcase
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = SEND;
      SEND:    if (frame_end && last_char) state_next = (idx == LAST) ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      idx      <= '0;
      val      <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) idx <= '0;
        end
        FETCH: begin
          // The captured value feeds both hex characters of this register.
          val      <= rd[7:0];
          shift    <= hex_char(rd[7:4]);
          char_idx <= '0;
          bit_idx  <= '0;
          clk_cnt  <= '0;
          txd      <= 1'b0;
        end
        SEND: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
              if (!last_char) begin
                shift    <= next_char;
                char_idx <= char_idx + 2'd1;
                bit_idx  <= '0;
                txd      <= 1'b0;
              end else if (idx != LAST) begin
                idx <= idx + AW'(1);
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx == 4'd8) begin
                txd <= 1'b1;
              end else begin
                txd   <= shift[0];
                shift <= {1'b0, shift[7:1]};
              end
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_uart_dump.sv
// Scoreboard bench for regfile_uart_dump at CLKS_PER_BIT=4: expected bytes are
// queued at stimulus time and a UART decoder pops and compares each frame.
module tb_regfile_uart_dump;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] ra;
  logic [7:0] rd;
  logic       uart_txd;
  logic       busy;
  logic       done;

  logic [7:0] regs [8];
  logic [7:0] exp_q [$];
  int         starts_q [$];
  logic [9:0] bits_q [$];
  logic [2:0] ra_log [$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  regfile_uart_dump #(.CLKS_PER_BIT(CPB), .NREGS(8), .AW(3), .DW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ra(ra), .rd(rd),
    .uart_txd(uart_txd), .busy(busy), .done(done)
  );

  assign rd = regs[ra];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART decoder / scoreboard monitor
  logic [39:0] mon_s;
  logic [9:0]  mon_bits;
  bit          mon_abort;
  bit          mon_stable;
  initial begin
    forever begin
      @(negedge clk);
      if (uart_txd === 1'b0 && rst !== 1'b1) begin
        starts_q.push_back(cyc);
        mon_s     = '0;
        mon_abort = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (rst !== 1'b0) mon_abort = 1'b1;
          mon_s[i] = uart_txd;
        end
        if (!mon_abort) begin
          mon_stable = 1'b1;
          for (int b = 0; b < 10; b++) begin
            mon_bits[b] = mon_s[4*b];
            for (int j = 1; j < 4; j++)
              if (mon_s[4*b+j] !== mon_s[4*b]) mon_stable = 1'b0;
          end
          bits_q.push_back(mon_bits);
          check("bit_width", mon_stable, 1'b1);
          check("stop_bit", mon_bits[9], 1'b1);
          if (exp_q.size() == 0) check("unexpected_byte", mon_bits[8:1], 32'hFFFF);
          else                   check("byte", mon_bits[8:1], exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1 && (ra_log.size() == 0 || ra !== ra_log[$])) ra_log.push_back(ra);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_regs(input logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7);
    regs[0] = r0; regs[1] = r1; regs[2] = r2; regs[3] = r3;
    regs[4] = r4; regs[5] = r5; regs[6] = r6; regs[7] = r7;
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    bit ok = 1'b0;
    dcyc = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcyc = cyc;
        ok   = 1'b1;
        break;
      end
    end
    check("done_seen", ok, 1'b1);
  endtask

  task automatic wait_starts(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (starts_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("start_bit_seen", ok, 1'b1);
  endtask

  int d1, d2, dc0;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_regs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ra", ra, 3'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_txd", uart_txd, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_ra", ra, 3'd0);
    end

    // Full dump with timing, bit pattern and address walk
    set_regs(8'hDB, 8'hCA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE);
    starts_q.delete(); bits_q.delete(); ra_log.delete();
    dc0 = done_cnt;
    push_line("DB CA 00 00 00 00 00 FE");
    pulse_start();
    @(negedge clk);
    check("fetch_busy", busy, 1'b1);
    check("fetch_ra", ra, 3'd0);
    check("fetch_txd_high", uart_txd, 1'b1);
    wait_done(d1);
    check("dump_bytes", starts_q.size(), 25);
    if (starts_q.size() == 25) begin
      check("done_latency", d1 - starts_q[0], 1007);
      for (int n = 1; n < 25; n++)
        check("byte_start_offset", starts_q[n] - starts_q[0], 40*n + ((n/3 < 7) ? n/3 : 7));
    end
    if (bits_q.size() > 0) check("bits_of_D", bits_q[0], 10'h288);
    check("ra_steps", ra_log.size(), 8);
    for (int i = 0; i < 8 && i < ra_log.size(); i++) check("ra_value", ra_log[i], i);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("done_single_cycle", done, 1'b0);
    check("done_count", done_cnt - dc0, 1);
    check("queue_drained", exp_q.size(), 0);

    // Hex digit edges
    repeat (5) @(negedge clk);
    set_regs(8'h09, 8'h0A, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    push_line("09 0A F0 00 00 00 00 00");
    pulse_start();
    wait_done(d1);
    @(negedge clk);
    check("hex_queue_drained", exp_q.size(), 0);

    // start held high: one dump while busy, retrigger after done; reg write mid-character
    repeat (5) @(negedge clk);
    set_regs(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88);
    starts_q.delete();
    dc0 = done_cnt;
    push_line("11 22 33 44 C4 66 77 88");
    push_line("11 22 33 A5 C4 66 77 88");
    @(posedge clk); #1 start = 1'b1;
    wait_starts(11);
    repeat (20) @(negedge clk);
    regs[3] = 8'hA5;
    regs[4] = 8'hC4;
    wait_done(d1);
    check("first_dump_bytes", starts_q.size(), 25);
    @(negedge clk);
    check("retrig_idle_busy", busy, 1'b0);
    @(negedge clk);
    check("retrig_fetch_busy", busy, 1'b1);
    start = 1'b0;
    wait_starts(26);
    if (starts_q.size() >= 26) check("retrig_start_bit", starts_q[25] - d1, 3);
    wait_done(d2);
    check("retrig_done_count", done_cnt - dc0, 2);
    @(negedge clk);
    check("retrig_queue_drained", exp_q.size(), 0);

    // Reset during bit 4 of the 6th byte
    repeat (5) @(negedge clk);
    set_regs(8'hDB, 8'hCA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE);
    starts_q.delete();
    push_line("DB CA 00 00 00 00 00 FE");
    pulse_start();
    wait_starts(6);
    repeat (17) @(negedge clk);
    dc0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_txd", uart_txd, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_ra", ra, 3'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (50) @(negedge clk);
    check("midrst_no_done", done_cnt - dc0, 0);
    check("midrst_line_idle", uart_txd, 1'b1);
    starts_q.delete();
    push_line("DB CA 00 00 00 00 00 FE");
    pulse_start();
    wait_done(d1);
    check("post_rst_bytes", starts_q.size(), 25);
    @(negedge clk);
    check("post_rst_queue_drained", exp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_uart_dump.md
# regfile_uart_dump

Serial dump engine for the 8 × 8-bit register file. On a start pulse it walks register addresses 0..7 through one register-file read port, converts each value to two ASCII hex characters, and transmits the line over 8N1 UART on `UART_TXD`. It sits directly downstream of the register file's read side, sharing it with the HEX/LCD display path through a board-level mux that hands the read address to this block while `busy` is high.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `NREGS`, 8: registers dumped, addresses 0..NREGS-1.
- `AW`, 3: read-address width.
- `DW`, 8: register data width. Fixed at 8, so each value is two hex characters.

Ports:
- `clk` in 1: single clock (CLOCK_50 domain); all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a dump. Sampled only in IDLE. A level is accepted once per dump.
- `ra` out AW: read address to the register file.
- `rd` in DW: combinational read data for `ra`.
- `uart_txd` out 1: serial output, idle high.
- `busy` out 1: high from the cycle after `start` is accepted until the dump ends.
- `done` out 1: one-cycle pulse when the dump completes.

## Operation
- States:
  - IDLE: `uart_txd`=1, `busy`=0.
  - FETCH: one cycle. `ra` = current index. The line is held high.
  - SEND: serialises the byte in the shift register.
  - DONE: one cycle.
- Character stream for register i, with value v:
  - `hex(v[7:4])`, then `hex(v[3:0])`.
  - Then a separator: 0x20 (space) for i < NREGS-1; for i = NREGS-1, 0x0D then 0x0A.
- Hex encoding uses uppercase: 0–9 → 0x30–0x39, A–F → 0x41–0x46.
- Total bytes per dump = 3·NREGS + 1, which is 25 at the defaults.
- Data capture:
  - `rd` is captured into an 8-bit value register on the clock edge that leaves FETCH.
  - The captured value is used for both hex characters. Register-file writes during SEND do not affect the characters already in progress for that register.
- Transitions:
  - IDLE → FETCH when `start`=1. The index is cleared to 0.
  - FETCH → SEND. The first character of register i is loaded.
  - SEND, after the stop bit of the last character of register i:
    - → FETCH with index i+1, if i < NREGS-1;
    - otherwise → DONE.
  - DONE → IDLE. `done`=1 for this cycle only.
  - Characters within one register are sent back to back, with no idle cycle between the stop bit and the next start bit.
- Frame: start bit 0, data bits d0..d7 (LSB first), stop bit 1. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Bit counter: wraps 0..CLKS_PER_BIT-1. Index: 0..NREGS-1, with no wrap past NREGS-1.
- `ra` holds the last index outside FETCH. It resets to 0.
- `start` is ignored while `busy`=1. There is no queueing.
- `start` still high in the cycle DONE returns to IDLE launches a new dump on the next edge.

## Timing
- Reset values: `uart_txd`=1, `busy`=0, `done`=0, `ra`=0. State is IDLE; counters and the shift register are 0.
- `rst` asserted mid-frame forces the reset values on the next edge, so `uart_txd` goes high immediately. No partial frame completes. `done` does not pulse.
- Sequence for `start` sampled high at edge k:
  - Edge k: state becomes FETCH, `busy`=1, `ra`=0.
  - Edge k+1: `rd` is captured and `uart_txd`=0 (start bit of the first character).
  - Each character lasts 10·CLKS_PER_BIT cycles.
  - Each later register adds exactly 1 FETCH cycle with the line high.
- Dump length, from the first start bit to `done`:
  - The last stop bit ends at 25·10·CLKS_PER_BIT + 7 cycles after edge k+1.
  - `done`=1 in the following cycle. `busy`=0 from the edge after that.
- `busy` high duration = 1 + 250·CLKS_PER_BIT + 7 + 1 cycles at the defaults.
- The output is registered, with no combinational path from `start` or `rd` to `uart_txd`.

## Test plan
Use `CLKS_PER_BIT`=4 for all scenarios.
- Reset/idle: hold `rst` 3 cycles, then pulse `start`=0 → `uart_txd`=1, `busy`=0, `done`=0, `ra`=0 throughout.
- Full dump: regfile = {DB,CA,00,00,00,00,00,FE} at addresses 0..7, pulse `start` → decoded bytes are "DB CA 00 00 00 00 00 FE\r\n" (25 bytes). `ra` steps 0..7. `done` pulses once, 1007 cycles after the first start bit, and `busy` falls the cycle after.
- Bit timing: every bit is exactly 4 cycles; LSB first; 'D' (0x44) is sent as 0,0,0,1,0,0,0,1,0,1. There is exactly one high cycle between the LF of one register… between the separator of register i and the start bit of register i+1.
- Hex edges: reg values 0x09, 0x0A, 0xF0 → characters "09", "0A", "F0" (0x30 0x39, 0x30 0x41, 0x46 0x30).
- Ignore/retrigger: `start` held high through a whole dump → exactly one dump while `busy`, then a second dump begins the cycle after `done`. A write to reg 3 during its low-nibble character → the characters keep the old value; reg 4 onward reflects new contents.
- Mid-frame reset: assert `rst` during bit 4 of the 6th byte → `uart_txd`=1 and `busy`=0 next edge, no `done`. A new `start` produces a complete, correct 25-byte dump.
